// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for the 7-segment scan driver: the active-low
//               glyph table, the all-off segment pattern and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // All segments and the decimal point dark (active-low outputs)
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    // Glyph value that blanks g..a while leaving dp to the caller
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] GLYPH_ROM [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int width_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : seg_glyph_rom
// Description : Combinational hex nibble to active-low 7-segment glyph lookup
//               (decimal point handled outside).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_ROM[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Round-robin multiplexed driver for a bank of common-anode
//               7-segment digits with frame-synchronous shadowing, a blanking
//               gap at the start of every slot and leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  lz_en,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     anode
);

    localparam int IDX_W = width_for(DIGITS);
    localparam int CNT_W = width_for(SLOT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic                slot_end;
    logic                frame_end;
    logic [4*DIGITS-1:0] stage_data;
    logic [DIGITS-1:0]   stage_dp;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [DIGITS-1:0]   lz_mask;
    logic                in_blank;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic [6:0]          cur_glyph;
    logic [DIGITS-1:0]   anode_sel;

    assign slot_end  = (slot_cnt == LAST_CNT);
    assign frame_end = slot_end && (digit_idx == LAST_IDX);

    // Scan position: slot counter and digit index, plus the frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (slot_end) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                slot_cnt  <= slot_cnt + CNT_W'(1);
            end
        end
    end

    // Load handshake: capture into staging, commit to shadow only on the
    // frame-boundary edge so a frame is always drawn from one snapshot. A load
    // on that same edge still lets the older staged value commit first.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data  <= '0;
            stage_dp    <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            busy        <= 1'b0;
        end else begin
            if (frame_end && busy) begin
                shadow_data <= stage_data;
                shadow_dp   <= stage_dp;
            end
            if (load) begin
                stage_data <= data;
                stage_dp   <= dp;
                busy       <= 1'b1;
            end else if (frame_end) begin
                busy       <= 1'b0;
            end
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero;
    // digit 0 always shows so a zero value still reads "0".
    assign lz_mask[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_lz
        assign lz_mask[i] = (shadow_data[4*DIGITS-1:4*i] == '0);
    end

    // Anodes stay dark for the first BLANK_CYCLES of every slot
    if (BLANK_CYCLES > 0) begin : g_blank
        assign in_blank = (slot_cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_blank
        assign in_blank = 1'b0;
    end

    assign cur_nibble = shadow_data[{digit_idx, 2'b00} +: 4];
    assign cur_dp     = shadow_dp[digit_idx];

    seg_glyph_rom u_glyph_rom (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    // One-cold decode of the selected digit
    always_comb begin
        anode_sel = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                anode_sel[i] = 1'b0;
            end
        end
    end

    // Registered pin drivers; segment keeps the glyph through the blank gap
    always_ff @(posedge clk) begin
        if (rst) begin
            segment <= SEG_OFF;
            anode   <= '1;
        end else begin
            segment <= {~cur_dp, (lz_en && lz_mask[digit_idx]) ? SEG_BLANK : cur_glyph};
            anode   <= in_blank ? '1 : anode_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed self-checking bench for seg_scan_driver
//               (DIGITS=4, SLOT_CYCLES=4, BLANK_CYCLES=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic        lz_en;
    logic        busy;
    logic        frame_done;
    logic [7:0]  segment;
    logic [3:0]  anode;

    int checks = 0;
    int errors = 0;

    // Value the display is expected to show in the frame being checked
    logic [15:0] shown_data;
    logic [3:0]  shown_dp;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS       (4),
        .SLOT_CYCLES  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .load       (load),
        .lz_en      (lz_en),
        .busy       (busy),
        .frame_done (frame_done),
        .segment    (segment),
        .anode      (anode)
    );

    // Reference segment pattern for one digit of a 4-digit value
    function automatic logic [7:0] exp_seg(input logic [15:0] d, input logic [3:0] p,
                                           input logic lz, input int dig);
        logic [3:0]  nib;
        logic [6:0]  g;
        logic [15:0] upper;
        nib   = d[dig*4 +: 4];
        upper = d >> (dig * 4);
        case (nib)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        if (lz && dig >= 1 && upper == 16'h0000) g = 7'h7F;
        return {~p[dig], g};
    endfunction

    // Advance to the next negedge at which frame_done is high (bounded)
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        rst = 1'b1; load = 1'b0; lz_en = 1'b0; data = 16'h0000; dp = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (segment !== 8'hFF || anode !== 4'hF || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init segment=%h anode=%h busy=%b fd=%b want FF F 0 0",
                     segment, anode, busy, frame_done);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        data = 16'hFFFF; dp = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prepend busy=%b want 1", busy);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (segment !== 8'hFF || anode !== 4'hF || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d segment=%h anode=%h busy=%b want FF F 0",
                         k, segment, anode, busy);
            end
        end
        rst = 1'b0;
        shown_data = 16'h0000; shown_dp = 4'h0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            exp_an = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
            exp_sg = exp_seg(shown_data, shown_dp, lz_en, j / 4);
            checks++;
            if (anode !== exp_an || segment !== exp_sg || frame_done !== (j == 15) || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_restart j=%0d anode=%h/%h seg=%h/%h fd=%b/%b busy=%b/0",
                         j, anode, exp_an, segment, exp_sg, frame_done, j == 15, busy);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        bit ok;
        data = 16'h12AF; dp = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL scan_busy busy=%b want 1", busy);
        end
        wait_frame(ok);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL scan_commit sync=%b busy=%b want sync 1 busy 0", ok, busy);
        end
        shown_data = 16'h12AF; shown_dp = 4'b0100;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            exp_an = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
            exp_sg = exp_seg(shown_data, shown_dp, lz_en, j / 4);
            checks++;
            if (anode !== exp_an || segment !== exp_sg || frame_done !== (j == 15)) begin
                errors++;
                $display("FAIL scan j=%0d anode=%h/%h seg=%h/%h fd=%b/%b",
                         j, anode, exp_an, segment, exp_sg, frame_done, j == 15);
            end
        end
    endtask

    task automatic test_tear_free();
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        logic       exp_busy;
        bit ok;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tear_sync got timeout want frame_done"); end
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                exp_an   = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
                exp_sg   = exp_seg(shown_data, shown_dp, lz_en, j / 4);
                exp_busy = (f == 0) && (j >= 4) && (j < 15);
                checks++;
                if (anode !== exp_an || segment !== exp_sg || busy !== exp_busy || frame_done !== (j == 15)) begin
                    errors++;
                    $display("FAIL tear f=%0d j=%0d anode=%h/%h seg=%h/%h busy=%b/%b fd=%b/%b",
                             f, j, anode, exp_an, segment, exp_sg, busy, exp_busy, frame_done, j == 15);
                end
                if (f == 0 && j == 3) begin data = 16'h4567; dp = 4'b0001; load = 1'b1; end
                if (f == 0 && j == 4) load = 1'b0;
            end
            shown_data = 16'h4567; shown_dp = 4'b0001;
        end
    endtask

    task automatic test_last_write();
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        logic       exp_busy;
        bit ok;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lastwr_sync got timeout want frame_done"); end
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                exp_an   = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
                exp_sg   = exp_seg(shown_data, shown_dp, lz_en, j / 4);
                exp_busy = (f == 0) && (j >= 2) && (j < 15);
                checks++;
                if (anode !== exp_an || segment !== exp_sg || busy !== exp_busy) begin
                    errors++;
                    $display("FAIL last_write f=%0d j=%0d anode=%h/%h seg=%h/%h busy=%b/%b",
                             f, j, anode, exp_an, segment, exp_sg, busy, exp_busy);
                end
                if (f == 0 && j == 1) begin data = 16'h1111; dp = 4'h0; load = 1'b1; end
                if (f == 0 && j == 2) load = 1'b0;
                if (f == 0 && j == 5) begin data = 16'h2222; load = 1'b1; end
                if (f == 0 && j == 6) load = 1'b0;
            end
            shown_data = 16'h2222; shown_dp = 4'h0;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        logic       exp_busy;
        bit ok;
        wait_frame(ok);
        data = 16'h9999; dp = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL boundary_sync got timeout want frame_done"); end
        shown_data = 16'h9999; shown_dp = 4'h0;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                exp_an   = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
                exp_sg   = exp_seg(shown_data, shown_dp, lz_en, j / 4);
                exp_busy = ((f == 0) && (j >= 3)) || ((f == 1) && (j < 15));
                checks++;
                if (anode !== exp_an || segment !== exp_sg || busy !== exp_busy || frame_done !== (j == 15)) begin
                    errors++;
                    $display("FAIL boundary f=%0d j=%0d anode=%h/%h seg=%h/%h busy=%b/%b fd=%b/%b",
                             f, j, anode, exp_an, segment, exp_sg, busy, exp_busy, frame_done, j == 15);
                end
                if (f == 0 && j == 2)  begin data = 16'h2222; load = 1'b1; end
                if (f == 0 && j == 3)  load = 1'b0;
                if (f == 0 && j == 14) begin data = 16'h3333; load = 1'b1; end
                if (f == 0 && j == 15) load = 1'b0;
            end
            shown_data = (f == 0) ? 16'h2222 : 16'h3333;
        end
    endtask

    task automatic test_lz();
        logic [3:0]  exp_an;
        logic [7:0]  exp_sg;
        logic [15:0] vals [2];
        bit ok;
        vals[0] = 16'h0005;
        vals[1] = 16'h0000;
        lz_en = 1'b1;
        for (int v = 0; v < 2; v++) begin
            data = vals[v]; dp = 4'h0; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_frame(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL lz_sync got timeout want frame_done"); end
            shown_data = vals[v]; shown_dp = 4'h0;
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                exp_an = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
                exp_sg = exp_seg(shown_data, shown_dp, lz_en, j / 4);
                checks++;
                if (anode !== exp_an || segment !== exp_sg) begin
                    errors++;
                    $display("FAIL lz v=%h j=%0d anode=%h/%h seg=%h/%h",
                             vals[v], j, anode, exp_an, segment, exp_sg);
                end
            end
        end
        lz_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_last_write();
        test_back_to_back();
        test_lz();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a bank of DIGITS 7-segment digits (common-anode, active-low).
- Takes packed hex nibbles plus decimal-point bits and latches them through a frame-synchronous shadow register so the display never tears.
- Scans the digits round-robin with a programmable slot length and an inter-digit blanking gap, with optional leading-zero suppression.
- Sits between the display-data producer (CPU bus register or counter logic) and the board's segment/anode pins.

Parameters:
- DIGITS, 4, number of digits scanned; must be >= 2.
- SLOT_CYCLES, 50000, clock cycles each digit is selected; must be > BLANK_CYCLES.
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (anti-ghosting); 0 disables the gap.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data  input  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 is rightmost
- dp  input  DIGITS  decimal point per digit, 1 = lit
- load  input  1  request to capture data/dp
- lz_en  input  1  leading-zero suppression enable (live, not shadowed)
- busy  output  1  load captured but not yet committed to the display
- frame_done  output  1  one-cycle pulse when the last digit's slot ends
- segment  output  8  {dp,g,f,e,d,c,b,a}, active-low
- anode  output  DIGITS  digit select, active-low

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values:
  - slot counter = 0, digit index = 0.
  - shadow data = 0, shadow dp = 0, pending staging = 0, busy = 0, frame_done = 0.
  - segment = 8'hFF, anode = all 1s.
- Reset mid-frame aborts the scan and discards any pending load.
- Slot counter runs 0..SLOT_CYCLES-1 and wraps to 0. On wrap, the digit index advances and wraps DIGITS-1 -> 0.
- frame_done is asserted in the cycle the index wraps to 0, registered.
- Load handshake:
  - load=1 copies data/dp into a staging register and sets busy next cycle.
  - The staging register commits to the shadow at the next frame boundary, i.e. the same cycle frame_done is asserted; busy clears that cycle.
  - load while busy overwrites staging, last write wins; busy stays 1.
  - load in the exact frame-boundary cycle: the new value goes to staging and busy stays 1. The previously staged value still commits.
- Decode uses a glyph ROM of 16 entries, dp excluded. Active-low g..a for 0..F:
  - 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78
  - 0x00, 0x10, 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E
- segment[7] = ~dp of the selected digit.
- Leading-zero suppression, when lz_en=1:
  - Digit i (i >= 1) is blank (segment[6:0] = 7'h7F) if shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - dp still follows the shadow dp.
- Blanking: anode = all 1s while slot counter < BLANK_CYCLES. Otherwise only anode[index] = 0.
- Output timing:
  - segment and anode are registered; they reflect index/counter state with exactly 1 cycle latency.
  - segment holds the selected digit's glyph during the blank gap as well.

Decomposition:
- Shared package seg_pkg:
  - glyph ROM constant (16 x 7 bits, active-low);
  - SEG_OFF = 8'hFF;
  - localparam helper for $clog2-sized index and counter widths.
- Natural sub-module: seg_glyph_rom (combinational nibble -> 7-bit glyph), instantiated once on the muxed nibble.
- The remaining logic is a single sequential module: counters, staging/shadow, LZ mask, output registers.

Test Plan:
- Use DIGITS=4, SLOT_CYCLES=4, BLANK_CYCLES=1 for all scenarios.
- Reset: hold rst 3 cycles mid-scan -> segment=8'hFF, anode=4'hF, busy=0, and index restarts at 0 on release.
- Scan: load data=16'h12AF, dp=4'b0100, after commit -> per slot, anode goes 4'hF for 1 cycle then:
  - 4'hE with segment=8'h8E;
  - 4'hD with 8'h88;
  - 4'hB with 8'h24 (dp lit);
  - 4'h7 with 8'hF9.
  - frame_done pulses every 16 cycles.
- Tear-free commit: load mid-frame -> busy=1 until the frame_done cycle; the old value is displayed for the rest of the frame.
- Last write wins: two loads (16'h1111 then 16'h2222) in one frame -> only 2222 is ever displayed.
- Boundary collision: load 16'h3333 in the frame_done cycle while 16'h2222 is pending -> 2222 commits, busy stays 1, 3333 commits at the next boundary.
- Leading-zero suppression: lz_en=1, data=16'h0005 -> digits 3..1 show 8'hFF and digit 0 shows 8'h92. data=16'h0000 -> only digit 0 shows 8'hC0.
